npn4_tt_sweeper: RTL and testbench

//  Exhaustive stimulus/capture stage wrapped around one 4-input single-output AIG cell (x0..x3 -> y0).

---
 rtl/npn4_pkg.sv | 25 ++
 rtl/npn4_tt_sweeper_if.sv | 27 ++
 rtl/npn4_xform.sv | 18 +
 rtl/npn4_tt_sweeper.sv | 162 ++++++++++++++++
 tb/tb_npn4_tt_sweeper.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/npn4_pkg.sv
// Shared types for the NPN4 truth-table sweeper: FSM states, permutation type
// and the permutation validity check.
package npn4_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // perm[i] is the raw-minterm bit index that drives cell input x_i
    typedef logic [3:0][1:0] perm_t;

    localparam perm_t IDENT_PERM = 8'hE4;

    function automatic logic perm_valid(perm_t p);
        logic [3:0] seen;
        seen = '0;
        for (int i = 0; i < 4; i++) begin
            seen[p[i]] = 1'b1;
        end
        return (seen == 4'hF);
    endfunction

endpackage

// File: rtl/npn4_tt_sweeper_if.sv
// Control/status bundle between the sweeper and whatever sequences it.
interface npn4_tt_sweeper_if;
    import npn4_pkg::*;

    logic        start;
    logic        abort;
    logic [3:0]  neg_mask;
    perm_t       perm;
    logic        out_neg;
    logic [15:0] expected_tt;
    logic        busy;
    logic        done;
    logic [15:0] tt;
    logic        match;
    logic        perm_err;

    modport master (
        output start, abort, neg_mask, perm, out_neg, expected_tt,
        input  busy, done, tt, match, perm_err
    );

    modport slave (
        input  start, abort, neg_mask, perm, out_neg, expected_tt,
        output busy, done, tt, match, perm_err
    );

endinterface

// File: rtl/npn4_xform.sv
// NPN input transform: permute raw minterm bits, then apply input negation.
module npn4_xform
    import npn4_pkg::*;
(
    input  logic [3:0] m_i,
    input  perm_t      perm_i,
    input  logic [3:0] neg_mask_i,
    output logic [3:0] a_o
);

    always_comb begin
        a_o = '0;
        for (int i = 0; i < 4; i++) begin
            a_o[i] = m_i[perm_i[i]] ^ neg_mask_i[i];
        end
    end

endmodule

// File: rtl/npn4_tt_sweeper.sv
// Walks all 16 minterms through an NPN transform into a 4-input cell and
// captures the cell's truth table for comparison with an expected table.
//
//  state | meaning
//  IDLE  | waiting for start; config not yet latched
//  RUN   | driving minterm m, counting settle cycles, sampling y0
//  DONE  | one-cycle done pulse, result and match held afterwards
module npn4_tt_sweeper
    import npn4_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    npn4_tt_sweeper_if.slave   ctl,
    output logic               x0,
    output logic               x1,
    output logic               x2,
    output logic               x3,
    input  logic               y0
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  m_q, m_d;
    logic [3:0]  settle_q, settle_d;
    logic [3:0]  x_q, x_d;
    logic [15:0] tt_q, tt_d;
    logic        match_q, match_d;
    logic        perm_err_q, perm_err_d;
    logic [3:0]  neg_q, neg_d;
    perm_t       perm_q, perm_d;
    logic        out_neg_q, out_neg_d;
    logic [15:0] exp_q, exp_d;

    logic [3:0]  xf_m;
    perm_t       xf_perm;
    logic [3:0]  xf_neg;
    logic [3:0]  xf_a;

    // In IDLE the transform sees the live config so minterm 0 is registered on
    // the accepting edge; in RUN it precomputes the next minterm.
    always_comb begin
        xf_m    = 4'(m_q + 4'd1);
        xf_perm = perm_q;
        xf_neg  = neg_q;
        if (state_q == IDLE) begin
            xf_m    = 4'd0;
            xf_perm = ctl.perm;
            xf_neg  = ctl.neg_mask;
        end
    end

    npn4_xform u_xform (
        .m_i        (xf_m),
        .perm_i     (xf_perm),
        .neg_mask_i (xf_neg),
        .a_o        (xf_a)
    );

    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        settle_d   = settle_q;
        x_d        = x_q;
        tt_d       = tt_q;
        match_d    = match_q;
        perm_err_d = perm_err_q;
        neg_d      = neg_q;
        perm_d     = perm_q;
        out_neg_d  = out_neg_q;
        exp_d      = exp_q;

        case (state_q)
            IDLE: begin
                if (ctl.start && !ctl.abort) begin
                    if (perm_valid(ctl.perm)) begin
                        state_d    = RUN;
                        m_d        = 4'd0;
                        settle_d   = SETTLE_LOAD;
                        x_d        = xf_a;
                        tt_d       = '0;
                        match_d    = 1'b0;
                        perm_err_d = 1'b0;
                        neg_d      = ctl.neg_mask;
                        perm_d     = ctl.perm;
                        out_neg_d  = ctl.out_neg;
                        exp_d      = ctl.expected_tt;
                    end else begin
                        perm_err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (ctl.abort) begin
                    state_d = IDLE;
                    x_d     = '0;
                    match_d = 1'b0;
                end else if (settle_q != 4'd0) begin
                    settle_d = 4'(settle_q - 4'd1);
                end else begin
                    tt_d[m_q] = y0 ^ out_neg_q;
                    if (m_q == 4'd15) begin
                        state_d = DONE;
                        x_d     = '0;
                        match_d = (tt_d == exp_q);
                    end else begin
                        m_d      = 4'(m_q + 4'd1);
                        settle_d = SETTLE_LOAD;
                        x_d      = xf_a;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            m_q        <= '0;
            settle_q   <= '0;
            x_q        <= '0;
            tt_q       <= '0;
            match_q    <= 1'b0;
            perm_err_q <= 1'b0;
            neg_q      <= '0;
            perm_q     <= IDENT_PERM;
            out_neg_q  <= 1'b0;
            exp_q      <= '0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            settle_q   <= settle_d;
            x_q        <= x_d;
            tt_q       <= tt_d;
            match_q    <= match_d;
            perm_err_q <= perm_err_d;
            neg_q      <= neg_d;
            perm_q     <= perm_d;
            out_neg_q  <= out_neg_d;
            exp_q      <= exp_d;
        end
    end

    assign x0           = x_q[0];
    assign x1           = x_q[1];
    assign x2           = x_q[2];
    assign x3           = x_q[3];
    assign ctl.busy     = (state_q == RUN);
    assign ctl.done     = (state_q == DONE);
    assign ctl.tt       = tt_q;
    assign ctl.match    = match_q;
    assign ctl.perm_err = perm_err_q;

endmodule

// File: tb/tb_npn4_tt_sweeper.sv
// Bench for npn4_tt_sweeper: registered AND2 cell (y0 = x0 & x1), directed
// corner cases plus random NPN configurations against a truth-table model.
module tb_npn4_tt_sweeper;
    import npn4_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic x0, x1, x2, x3;
    logic y0 = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    npn4_tt_sweeper_if ctl();

    npn4_tt_sweeper #(.SETTLE_CYCLES(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ctl),
        .x0    (x0),
        .x1    (x1),
        .x2    (x2),
        .x3    (x3),
        .y0    (y0)
    );

    always #5 clk = ~clk;

    // Cell under check: one register stage
    always @(posedge clk) y0 <= x0 & x1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cell input i takes raw minterm bit perm[i], optionally inverted
    function automatic logic [3:0] model_x(input logic [7:0] p, input logic [3:0] ng, input int m);
        logic [3:0] x;
        for (int i = 0; i < 4; i++) begin
            int src;
            src  = int'(p[2*i +: 2]);
            x[i] = 1'(((m >> src) & 1) ^ int'(ng[i]));
        end
        return x;
    endfunction

    function automatic logic [15:0] model_tt(input logic [7:0] p, input logic [3:0] ng, input logic on);
        logic [15:0] t;
        for (int m = 0; m < 16; m++) begin
            logic [3:0] xv;
            xv   = model_x(p, ng, m);
            t[m] = (xv[0] & xv[1]) ^ on;
        end
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] p, input logic [3:0] ng, input logic on, input logic [15:0] ex);
        ctl.perm        = p;
        ctl.neg_mask    = ng;
        ctl.out_neg     = on;
        ctl.expected_tt = ex;
    endtask

    task automatic count_done(input int cycles, output int nd);
        nd = 0;
        repeat (cycles) begin
            tick();
            if (ctl.done) nd++;
        end
    endtask

    // Returns with the done cycle visible
    task automatic do_sweep(input logic [7:0] p, input logic [3:0] ng, input logic on,
                            input logic [15:0] ex, input bit chk_x, input bit mid_start,
                            input string tag);
        logic [15:0] mtt;
        int e;
        mtt = model_tt(p, ng, on);
        set_cfg(p, ng, on, ex);
        ctl.start = 1'b1;
        tick();
        ctl.start = 1'b0;
        e = 1;
        chk({tag, "_busy"}, ctl.busy, 1);
        chk({tag, "_perm_err"}, ctl.perm_err, 0);
        while (!ctl.done && e < 200) begin
            if (chk_x && e <= 32)
                chk({tag, "_x"}, {x3, x2, x1, x0}, model_x(p, ng, (e - 1) / 2));
            if (mid_start && e == 5) begin
                set_cfg(8'hE4, ~ng, ~on, ~ex);
                ctl.start = 1'b1;
            end
            if (mid_start && e == 6) ctl.start = 1'b0;
            tick();
            e++;
        end
        chk({tag, "_latency"}, e, 33);
        chk({tag, "_done"}, ctl.done, 1);
        chk({tag, "_busy_done"}, ctl.busy, 0);
        chk({tag, "_tt"}, ctl.tt, mtt);
        chk({tag, "_match"}, ctl.match, (mtt == ex));
    endtask

    initial begin
        int nd;
        int e;
        int idx[4];
        logic [7:0] p;
        logic [3:0] ng;
        logic on;
        logic [15:0] mtt;
        logic [15:0] ex;

        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        set_cfg(8'hE4, 4'h0, 1'b0, 16'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", ctl.busy, 0);
        chk("rst_done", ctl.done, 0);
        chk("rst_tt", ctl.tt, 0);
        chk("rst_match", ctl.match, 0);
        chk("rst_perm_err", ctl.perm_err, 0);
        chk("rst_x", {x3, x2, x1, x0}, 0);
        rst_n = 1'b1;
        tick();

        do_sweep(8'hE4, 4'h0, 1'b0, 16'h8888, 1'b1, 1'b0, "ident");
        tick();
        chk("ident_pulse", ctl.done, 0);
        chk("ident_hold_tt", ctl.tt, 16'h8888);
        chk("ident_hold_match", ctl.match, 1);

        do_sweep(8'hE4, 4'b0011, 1'b0, 16'h1111, 1'b0, 1'b0, "neg");
        tick();
        do_sweep(8'hE4, 4'h0, 1'b1, 16'h1111, 1'b0, 1'b0, "oneg");
        tick();
        do_sweep(8'hC6, 4'h0, 1'b0, 16'hC0C0, 1'b1, 1'b0, "c6");
        tick();

        // start during DONE is ignored; the following IDLE cycle accepts it
        do_sweep(8'hE4, 4'h0, 1'b0, 16'h8888, 1'b0, 1'b0, "b2b");
        ctl.start = 1'b1;
        tick();
        chk("b2b_done_ignored", ctl.busy, 0);
        tick();
        ctl.start = 1'b0;
        chk("b2b_accept", ctl.busy, 1);
        e = 0;
        while (!ctl.done && e < 200) begin
            tick();
            e++;
        end
        chk("b2b_second_done", ctl.done, 1);
        chk("b2b_second_tt", ctl.tt, 16'h8888);
        tick();

        // duplicate index in perm
        set_cfg(8'hE0, 4'h0, 1'b0, 16'h0);
        ctl.start = 1'b1;
        tick();
        ctl.start = 1'b0;
        chk("bad_perm_err", ctl.perm_err, 1);
        chk("bad_perm_busy", ctl.busy, 0);
        count_done(40, nd);
        chk("bad_perm_no_done", nd, 0);
        chk("bad_perm_tt", ctl.tt, 16'h8888);
        chk("bad_perm_err_held", ctl.perm_err, 1);

        set_cfg(8'hE4, 4'h0, 1'b0, 16'h8888);
        ctl.start = 1'b1;
        ctl.abort = 1'b1;
        tick();
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        chk("abort_wins_busy", ctl.busy, 0);
        count_done(5, nd);
        chk("abort_wins_no_done", nd, 0);

        // abort while minterm 5 is on the cell inputs
        ctl.start = 1'b1;
        tick();
        ctl.start = 1'b0;
        chk("abort_perm_err_clr", ctl.perm_err, 0);
        e = 1;
        while (e < 11) begin
            tick();
            e++;
        end
        chk("abort_x5", {x3, x2, x1, x0}, model_x(8'hE4, 4'h0, 5));
        ctl.abort = 1'b1;
        tick();
        ctl.abort = 1'b0;
        chk("abort_busy", ctl.busy, 0);
        chk("abort_x", {x3, x2, x1, x0}, 0);
        chk("abort_match", ctl.match, 0);
        chk("abort_tt_partial", ctl.tt, model_tt(8'hE4, 4'h0, 1'b0) & 16'h001F);
        count_done(40, nd);
        chk("abort_no_done", nd, 0);

        do_sweep(8'hC6, 4'h0, 1'b0, 16'hC0C0, 1'b1, 1'b1, "busy_start");
        tick();
        set_cfg(8'hE4, 4'h0, 1'b0, 16'h8888);

        // async reset while minterm 9 is on the cell inputs
        set_cfg(8'hE4, 4'h5, 1'b0, 16'h0);
        ctl.start = 1'b1;
        tick();
        ctl.start = 1'b0;
        e = 1;
        while (e < 19) begin
            tick();
            e++;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", ctl.busy, 0);
        chk("midrst_done", ctl.done, 0);
        chk("midrst_tt", ctl.tt, 0);
        chk("midrst_match", ctl.match, 0);
        chk("midrst_x", {x3, x2, x1, x0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(40, nd);
        chk("midrst_no_done", nd, 0);
        chk("midrst_idle", ctl.busy, 0);

        for (int k = 0; k < 6; k++) begin
            idx = '{0, 1, 2, 3};
            for (int i = 3; i > 0; i--) begin
                int j;
                int t;
                j      = int'($urandom_range(0, i));
                t      = idx[i];
                idx[i] = idx[j];
                idx[j] = t;
            end
            for (int i = 0; i < 4; i++) p[2*i +: 2] = 2'(idx[i]);
            ng  = 4'($urandom_range(0, 15));
            on  = 1'($urandom_range(0, 1));
            mtt = model_tt(p, ng, on);
            ex  = ($urandom_range(0, 1) == 1) ? mtt : 16'($urandom);
            do_sweep(p, ng, on, ex, 1'b1, (k % 2) == 1, "rand");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
